// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with PWM brightness,
// double-buffered frame-aligned updates and leading-zero blanking.
module seg7_scan_driver #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 2048
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dots,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic [3:0]            brightness,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig,
  output logic                  pending,
  output logic                  frame_start
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(DIGITS - 1);

  logic [PW-1:0]         r_pre;
  logic [3:0]            r_slot;
  logic [SW-1:0]         r_scan;
  logic [4*DIGITS-1:0]   r_act_val;
  logic [DIGITS-1:0]     r_act_dots;
  logic [4*DIGITS-1:0]   r_pnd_val;
  logic [DIGITS-1:0]     r_pnd_dots;
  logic                  r_pending;
  logic [7:0]            r_seg;
  logic [DIGITS-1:0]     r_dig;
  logic                  r_bnd_d;
  logic                  r_frame_start;

  logic                  w_tick;
  logic                  w_swrap;
  logic                  w_bound;
  logic                  w_on;
  logic [3:0]            w_nib;
  logic                  w_dot;
  logic                  w_sup;
  logic [DIGITS-1:0]     w_onehot;
  logic [DIGITS-1:0]     w_supv;
  logic                  w_zacc;

  assign w_tick  = (r_pre == PMAX);
  assign w_swrap = w_tick && (r_slot == 4'hF);
  assign w_bound = w_swrap && (r_scan == SMAX);
  assign w_on    = (r_slot < brightness) && (r_slot != 4'hF);

  function automatic logic [6:0] f_dec(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Prescaler, PWM slot and scan-index counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pre  <= '0;
      r_slot <= '0;
      r_scan <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick)
        r_slot <= r_slot + 4'd1;
      if (w_swrap)
        r_scan <= (r_scan == SMAX) ? '0 : r_scan + 1'b1;
    end
  end

  // Pending/active buffers; active only changes on a frame boundary
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_act_val  <= '0;
      r_act_dots <= '0;
      r_pnd_val  <= '0;
      r_pnd_dots <= '0;
      r_pending  <= 1'b0;
    end else if (w_bound) begin
      r_pending <= 1'b0;
      if (load) begin
        r_act_val  <= value;
        r_act_dots <= dots;
      end else if (r_pending) begin
        r_act_val  <= r_pnd_val;
        r_act_dots <= r_pnd_dots;
      end
    end else if (load) begin
      r_pnd_val  <= value;
      r_pnd_dots <= dots;
      r_pending  <= 1'b1;
    end
  end

  // Select current digit data and leading-zero status
  always_comb begin
    w_nib    = 4'h0;
    w_dot    = 1'b0;
    w_sup    = 1'b0;
    w_onehot = '0;
    w_supv   = '0;
    w_zacc   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zacc    = w_zacc && (r_act_val[4*i +: 4] == 4'h0);
      w_supv[i] = w_zacc && (i != 0);
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scan == SW'(i)) begin
        w_nib       = r_act_val[4*i +: 4];
        w_dot       = r_act_dots[i];
        w_sup       = w_supv[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // Registered pin drive and frame-start pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_seg         <= 8'hFF;
      r_dig         <= '0;
      r_bnd_d       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_bnd_d       <= w_bound;
      r_frame_start <= r_bnd_d;
      if (w_on) begin
        r_seg <= {~w_dot, (lz_en && w_sup) ? 7'h7F : f_dec(w_nib)};
        r_dig <= w_onehot;
      end else begin
        r_seg <= 8'hFF;
        r_dig <= '0;
      end
    end
  end

  assign seg         = r_seg;
  assign dig         = r_dig;
  assign pending     = r_pending;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a position-based
// reference model predicts every registered output cycle.
module tb_seg7_scan_driver;

  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 2;
  localparam int FRAME   = DIGITS * 16 * CLK_DIV;

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic [4*DIGITS-1:0] value = '0;
  logic [DIGITS-1:0]   dots = '0;
  logic                load = 1'b0;
  logic                lz_en = 1'b0;
  logic [3:0]          brightness = 4'd15;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   dig;
  logic                pending;
  logic                frame_start;

  seg7_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
    .CLK(CLK), .RST(RST), .value(value), .dots(dots),
    .load(load), .lz_en(lz_en), .brightness(brightness),
    .seg(seg), .dig(dig), .pending(pending),
    .frame_start(frame_start)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]        seg;
    logic [DIGITS-1:0] dig;
    logic              pnd;
    logic              fs;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   tcyc    = 0;
  bit   armed   = 0;

  logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                           7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03,
                           7'h46, 7'h21, 7'h06, 7'h0E};

  logic [4*DIGITS-1:0] m_act = '0;
  logic [4*DIGITS-1:0] m_pbuf = '0;
  logic [DIGITS-1:0]   m_adots = '0;
  logic [DIGITS-1:0]   m_pdots = '0;
  bit                  m_pnd = 0;

  // Reference model: one expected output per rising edge
  initial begin
    int p, scan, slot;
    bit on, sup;
    logic [3:0] nib;
    exp_t e;
    forever begin
      @(posedge CLK);
      if (RST) begin
        q.delete();
        tcyc = 0;
        m_act = '0; m_pbuf = '0;
        m_adots = '0; m_pdots = '0;
        m_pnd = 0;
        continue;
      end
      p    = tcyc % FRAME;
      scan = p / (16 * CLK_DIV);
      slot = (p / CLK_DIV) % 16;
      on   = (slot < int'(brightness)) && (slot != 15);
      nib  = 4'(m_act >> (4 * scan));
      sup  = lz_en && (scan != 0) && ((m_act >> (4 * scan)) == 0);
      e.dig = on ? DIGITS'(1 << scan) : '0;
      e.seg = on ? {~m_adots[scan], sup ? 7'h7F : HEX[nib]} : 8'hFF;
      e.fs  = (p == 0) && (tcyc >= FRAME);
      if (p == FRAME - 1) begin
        if (load) begin
          m_act = value; m_adots = dots;
        end else if (m_pnd) begin
          m_act = m_pbuf; m_adots = m_pdots;
        end
        m_pnd = 0;
      end else if (load) begin
        m_pbuf = value; m_pdots = dots; m_pnd = 1;
      end
      e.pnd = m_pnd;
      q.push_back(e);
      tcyc++;
    end
  end

  // Monitor: pop and compare on every falling edge
  initial begin
    exp_t e, g;
    forever begin
      @(negedge CLK);
      if (RST || !armed) continue;
      vectors++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL queue_empty t=%0t no expected entry", $time);
      end else begin
        e = q.pop_front();
        g = {seg, dig, pending, frame_start};
        if (g !== e) begin
          errors++;
          $display("FAIL out t=%0t got seg=%h dig=%b pnd=%b fs=%b exp seg=%h dig=%b pnd=%b fs=%b",
                   $time, g.seg, g.dig, g.pnd, g.fs,
                   e.seg, e.dig, e.pnd, e.fs);
        end
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic do_load(input logic [4*DIGITS-1:0] v,
                         input logic [DIGITS-1:0] d);
    value = v;
    dots  = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic wait_pos(input int target);
    int n;
    n = 0;
    while ((tcyc % FRAME) != target && n <= FRAME) begin
      step();
      n++;
    end
    if ((tcyc % FRAME) != target) begin
      vectors++;
      errors++;
      $display("FAIL wait_pos target=%0d got=%0d", target, tcyc % FRAME);
    end
  endtask

  initial begin
    step(3);
    RST = 1'b0;
    armed = 1;

    step(FRAME + 20);
    brightness = 4'd15;
    do_load(16'h12A0, 4'b0000);
    step(2 * FRAME);

    wait_pos(40);
    do_load(16'hBEEF, 4'b0000);
    step(10);
    do_load(16'h3C7D, 4'b0101);
    step(2 * FRAME);

    lz_en = 1'b1;
    do_load(16'h0005, 4'b0000);
    step(2 * FRAME);
    do_load(16'h0000, 4'b0000);
    step(2 * FRAME);
    lz_en = 1'b0;
    step(FRAME);

    brightness = 4'd4;
    do_load(16'h9876, 4'b0000);
    step(2 * FRAME);
    brightness = 4'd0;
    step(FRAME);
    brightness = 4'd15;

    do_load(16'h4321, 4'b0010);
    step(2 * FRAME);
    wait_pos(FRAME - 1);
    do_load(16'hA5E1, 4'b1000);
    step(FRAME + 5);

    lz_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step($urandom_range(1, 200));
      brightness = 4'($urandom_range(0, 15));
      lz_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0)
        do_load(16'($urandom_range(0, 255)), 4'($urandom));
      else
        do_load(16'($urandom), 4'($urandom));
    end
    step(2 * FRAME);

    brightness = 4'd15;
    do_load(16'h8888, 4'b1111);
    step(2 * FRAME);
    wait_pos(FRAME / 2 + 3 * CLK_DIV);
    do_load(16'h1111, 4'b0000);
    RST = 1'b1;
    #1;
    vectors++;
    if (seg !== 8'hFF) begin
      errors++;
      $display("FAIL async_rst_seg got=%h exp=ff", seg);
    end
    vectors++;
    if (dig !== '0) begin
      errors++;
      $display("FAIL async_rst_dig got=%b exp=0", dig);
    end
    vectors++;
    if (pending !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_pnd got=%b exp=0", pending);
    end
    step(3);
    RST = 1'b0;
    step(2 * FRAME + 10);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
